// File: rtl/ctrl_ex.sv
// Execute-stage control for the 16-bit Thumb-subset pipeline: EX/MEM instruction register,
// ALU op/immediate decode, load-use bubble insertion and the LDR data-memory handshake.
module ctrl_ex #(
    parameter int          TIMEOUT = 16,
    parameter logic [15:0] NOP_IR  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_ir_ex,
    input  logic        i_dmem_ack,
    output logic [15:0] o_ir_mem_r,
    output logic [2:0]  o_alu_op_r,
    output logic [7:0]  o_imm_r,
    output logic        o_dmem_req_r,
    output logic        o_dmem_err_r,
    output logic        o_stall,
    output logic        o_hold
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_MOVI = 3'd3;
    localparam logic [2:0] OP_MOVR = 3'd4;
    localparam logic [2:0] OP_LDR  = 3'd5;

    logic [0:0]    state_r;
    logic [CW-1:0] cnt_r;

    logic [2:0] dec_op_s;
    logic [7:0] dec_imm_s;
    logic [3:0] dec_src_s;
    logic       dec_has_src_s;
    logic       mem_is_ldr_s;
    logic       hazard_s;
    logic       stall_s;

    // Decode the EX instruction into ALU op, immediate and source register
    always_comb begin
        dec_op_s      = OP_NOP;
        dec_imm_s     = 8'h00;
        dec_src_s     = 4'h0;
        dec_has_src_s = 1'b0;
        casez (i_ir_ex[15:7])
            9'b0001110??: begin
                dec_op_s      = OP_ADD;
                dec_imm_s     = {5'b00000, i_ir_ex[8:6]};
                dec_src_s     = {1'b0, i_ir_ex[5:3]};
                dec_has_src_s = 1'b1;
            end
            9'b101100001: begin
                dec_op_s      = OP_SUB;
                dec_imm_s     = {1'b0, i_ir_ex[6:0]};
                dec_src_s     = 4'd13;
                dec_has_src_s = 1'b1;
            end
            9'b00100????: begin
                dec_op_s  = OP_MOVI;
                dec_imm_s = i_ir_ex[7:0];
            end
            9'b01000110?: begin
                dec_op_s      = OP_MOVR;
                dec_src_s     = i_ir_ex[6:3];
                dec_has_src_s = 1'b1;
            end
            9'b01101????: begin
                dec_op_s      = OP_LDR;
                dec_imm_s     = {3'b000, i_ir_ex[10:6]};
                dec_src_s     = {1'b0, i_ir_ex[5:3]};
                dec_has_src_s = 1'b1;
            end
            default: begin
                dec_op_s      = OP_NOP;
                dec_imm_s     = 8'h00;
                dec_src_s     = 4'h0;
                dec_has_src_s = 1'b0;
            end
        endcase
    end

    assign mem_is_ldr_s = (o_ir_mem_r[15:11] == 5'b01101);
    // The LDR destination is only visible to consumers once it leaves MEM, hence the bubble.
    assign hazard_s     = mem_is_ldr_s && dec_has_src_s && (dec_src_s == {1'b0, o_ir_mem_r[2:0]});
    assign stall_s      = (state_r == ST_WAIT) && !i_dmem_ack;
    assign o_stall      = stall_s;
    assign o_hold       = stall_s || hazard_s;

    // EX/MEM register, op/imm registers and the LDR request FSM
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_ir_mem_r   <= NOP_IR;
            o_alu_op_r   <= OP_NOP;
            o_imm_r      <= 8'h00;
            o_dmem_req_r <= 1'b0;
            o_dmem_err_r <= 1'b0;
            state_r      <= ST_RUN;
            cnt_r        <= '0;
        end else begin
            o_dmem_err_r <= 1'b0;
            if (stall_s) begin
                if (cnt_r == CNT_LAST) begin
                    // Timeout: drop the request and squash the stuck LDR.
                    o_dmem_req_r <= 1'b0;
                    o_dmem_err_r <= 1'b1;
                    o_ir_mem_r   <= NOP_IR;
                    o_alu_op_r   <= OP_NOP;
                    o_imm_r      <= 8'h00;
                    state_r      <= ST_RUN;
                    cnt_r        <= '0;
                end else begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end else if (hazard_s) begin
                o_ir_mem_r   <= NOP_IR;
                o_alu_op_r   <= OP_NOP;
                o_imm_r      <= 8'h00;
                o_dmem_req_r <= 1'b0;
                state_r      <= ST_RUN;
            end else begin
                o_ir_mem_r <= i_ir_ex;
                o_alu_op_r <= dec_op_s;
                o_imm_r    <= dec_imm_s;
                if (dec_op_s == OP_LDR) begin
                    o_dmem_req_r <= 1'b1;
                    cnt_r        <= '0;
                    state_r      <= ST_WAIT;
                end else begin
                    o_dmem_req_r <= 1'b0;
                    state_r      <= ST_RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_ctrl_ex.sv
// Directed self-checking bench for ctrl_ex: decode, load-use bubble, LDR handshake and timeout.
module tb_ctrl_ex;

    logic        clk;
    logic        rst;
    logic [15:0] i_ir_ex;
    logic        i_dmem_ack;
    logic [15:0] o_ir_mem_r;
    logic [2:0]  o_alu_op_r;
    logic [7:0]  o_imm_r;
    logic        o_dmem_req_r;
    logic        o_dmem_err_r;
    logic        o_stall;
    logic        o_hold;

    int checks;
    int failures;

    ctrl_ex #(.TIMEOUT(16), .NOP_IR(16'h0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_ir_ex      (i_ir_ex),
        .i_dmem_ack   (i_dmem_ack),
        .o_ir_mem_r   (o_ir_mem_r),
        .o_alu_op_r   (o_alu_op_r),
        .o_imm_r      (o_imm_r),
        .o_dmem_req_r (o_dmem_req_r),
        .o_dmem_err_r (o_dmem_err_r),
        .o_stall      (o_stall),
        .o_hold       (o_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; i_ir_ex = 16'h0000; i_dmem_ack = 1'b0;
        tick(); tick();
        rst = 1'b1;
        i_ir_ex = 16'h680B;
        tick();
        checks++; if (o_dmem_req_r !== 1'b1) begin $display("FAIL reset_pre_req: got %b expected 1", o_dmem_req_r); failures++; end
        rst = 1'b0; i_ir_ex = 16'h0000;
        tick(); tick();
        #1;
        checks++; if (o_ir_mem_r !== 16'h0000) begin $display("FAIL reset_ir: got %h expected 0000", o_ir_mem_r); failures++; end
        checks++; if (o_alu_op_r !== 3'd0 || o_imm_r !== 8'h00) begin $display("FAIL reset_opimm: got %0d/%h expected 0/00", o_alu_op_r, o_imm_r); failures++; end
        checks++; if (o_dmem_req_r !== 1'b0 || o_dmem_err_r !== 1'b0) begin $display("FAIL reset_req_err: got %b%b expected 00", o_dmem_req_r, o_dmem_err_r); failures++; end
        checks++; if (o_stall !== 1'b0 || o_hold !== 1'b0) begin $display("FAIL reset_stall_hold: got %b%b expected 00", o_stall, o_hold); failures++; end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_decode();
        logic [15:0] irs  [4] = '{16'h1CD1, 16'h205A, 16'hB085, 16'h4608};
        logic [2:0]  ops  [4] = '{3'd1, 3'd3, 3'd2, 3'd4};
        logic [7:0]  imms [4] = '{8'h03, 8'h5A, 8'h05, 8'h00};
        for (int i = 0; i < 4; i++) begin
            i_ir_ex = irs[i];
            #1;
            checks++; if (o_hold !== 1'b0) begin $display("FAIL decode_hold[%0d]: got %b expected 0", i, o_hold); failures++; end
            tick();
            checks++; if (o_ir_mem_r !== irs[i]) begin $display("FAIL decode_ir[%0d]: got %h expected %h", i, o_ir_mem_r, irs[i]); failures++; end
            checks++; if (o_alu_op_r !== ops[i]) begin $display("FAIL decode_op[%0d]: got %0d expected %0d", i, o_alu_op_r, ops[i]); failures++; end
            checks++; if (o_imm_r !== imms[i]) begin $display("FAIL decode_imm[%0d]: got %h expected %h", i, o_imm_r, imms[i]); failures++; end
        end
        i_ir_ex = 16'h0000;
        tick();
    endtask

    task automatic test_ldr_ack3();
        int req_cycles = 0;
        int stall_cycles = 0;
        i_ir_ex = 16'h680B;
        tick();
        checks++; if (o_alu_op_r !== 3'd5 || o_imm_r !== 8'h00) begin $display("FAIL ldr_opimm: got %0d/%h expected 5/00", o_alu_op_r, o_imm_r); failures++; end
        i_ir_ex = 16'h0000;
        for (int c = 1; c <= 3; c++) begin
            i_dmem_ack = (c == 3);
            #1;
            if (o_dmem_req_r === 1'b1) req_cycles++;
            if (o_stall === 1'b1) stall_cycles++;
            checks++; if (o_ir_mem_r !== 16'h680B) begin $display("FAIL ldr_held[%0d]: got %h expected 680B", c, o_ir_mem_r); failures++; end
            tick();
        end
        i_dmem_ack = 1'b0;
        if (o_dmem_req_r === 1'b1) req_cycles++;
        checks++; if (req_cycles !== 3) begin $display("FAIL ldr_req_cycles: got %0d expected 3", req_cycles); failures++; end
        checks++; if (stall_cycles !== 2) begin $display("FAIL ldr_stall_cycles: got %0d expected 2", stall_cycles); failures++; end
        checks++; if (o_ir_mem_r !== 16'h0000 || o_stall !== 1'b0) begin $display("FAIL ldr_after: got %h/%b expected 0000/0", o_ir_mem_r, o_stall); failures++; end
    endtask

    task automatic test_load_use();
        i_ir_ex = 16'h680B;
        tick();
        i_ir_ex = 16'h1C5C; i_dmem_ack = 1'b1;
        #1;
        checks++; if (o_hold !== 1'b1 || o_stall !== 1'b0) begin $display("FAIL lu_hold: got hold=%b stall=%b expected 1/0", o_hold, o_stall); failures++; end
        tick();
        i_dmem_ack = 1'b0;
        checks++; if (o_ir_mem_r !== 16'h0000 || o_alu_op_r !== 3'd0 || o_dmem_req_r !== 1'b0) begin $display("FAIL lu_bubble: got %h/%0d/%b expected 0000/0/0", o_ir_mem_r, o_alu_op_r, o_dmem_req_r); failures++; end
        checks++; if (o_hold !== 1'b0) begin $display("FAIL lu_release: got %b expected 0", o_hold); failures++; end
        tick();
        checks++; if (o_ir_mem_r !== 16'h1C5C || o_alu_op_r !== 3'd1 || o_imm_r !== 8'h01) begin $display("FAIL lu_add: got %h/%0d/%h expected 1C5C/1/01", o_ir_mem_r, o_alu_op_r, o_imm_r); failures++; end
        i_ir_ex = 16'h0000;
        tick();
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        int err_cycles = 0;
        i_ir_ex = 16'h684B;
        tick();
        checks++; if (o_alu_op_r !== 3'd5 || o_imm_r !== 8'h01) begin $display("FAIL to_opimm: got %0d/%h expected 5/01", o_alu_op_r, o_imm_r); failures++; end
        i_ir_ex = 16'h2201;
        for (int i = 0; i < 20; i++) begin
            if (o_dmem_req_r === 1'b1) req_cycles++;
            if (o_dmem_err_r === 1'b1) err_cycles++;
            if (i == 15) begin
                checks++; if (o_stall !== 1'b1) begin $display("FAIL to_last_stall: got %b expected 1", o_stall); failures++; end
            end
            if (i == 16) begin
                checks++; if (o_dmem_err_r !== 1'b1 || o_ir_mem_r !== 16'h0000 || o_stall !== 1'b0) begin $display("FAIL to_squash: got err=%b ir=%h stall=%b expected 1/0000/0", o_dmem_err_r, o_ir_mem_r, o_stall); failures++; end
            end
            if (i == 17) begin
                checks++; if (o_ir_mem_r !== 16'h2201 || o_alu_op_r !== 3'd3) begin $display("FAIL to_next: got %h/%0d expected 2201/3", o_ir_mem_r, o_alu_op_r); failures++; end
            end
            tick();
        end
        checks++; if (req_cycles !== 16) begin $display("FAIL to_req_cycles: got %0d expected 16", req_cycles); failures++; end
        checks++; if (err_cycles !== 1) begin $display("FAIL to_err_cycles: got %0d expected 1", err_cycles); failures++; end
        i_ir_ex = 16'h0000;
        tick();
    endtask

    task automatic test_back_to_back();
        i_ir_ex = 16'h680B;
        tick();
        i_ir_ex = 16'h2201; i_dmem_ack = 1'b1;
        #1;
        checks++; if (o_hold !== 1'b0) begin $display("FAIL nodep_hold: got %b expected 0", o_hold); failures++; end
        tick();
        checks++; if (o_ir_mem_r !== 16'h2201 || o_imm_r !== 8'h01 || o_dmem_req_r !== 1'b0) begin $display("FAIL nodep_adv: got %h/%h/%b expected 2201/01/0", o_ir_mem_r, o_imm_r, o_dmem_req_r); failures++; end
        i_ir_ex = 16'h680B; i_dmem_ack = 1'b0;
        tick();
        i_ir_ex = 16'h684B; i_dmem_ack = 1'b1;
        tick();
        i_dmem_ack = 1'b0; i_ir_ex = 16'h0000;
        #1;
        checks++; if (o_ir_mem_r !== 16'h684B || o_dmem_req_r !== 1'b1 || o_stall !== 1'b1) begin $display("FAIL b2b_second: got %h req=%b stall=%b expected 684B/1/1", o_ir_mem_r, o_dmem_req_r, o_stall); failures++; end
        i_dmem_ack = 1'b1;
        tick();
        i_dmem_ack = 1'b0;
        checks++; if (o_dmem_req_r !== 1'b0 || o_ir_mem_r !== 16'h0000) begin $display("FAIL b2b_done: got req=%b ir=%h expected 0/0000", o_dmem_req_r, o_ir_mem_r); failures++; end
        i_dmem_ack = 1'b1;
        tick();
        i_dmem_ack = 1'b0;
        checks++; if (o_dmem_req_r !== 1'b0 || o_stall !== 1'b0) begin $display("FAIL ack_in_run: got req=%b stall=%b expected 0/0", o_dmem_req_r, o_stall); failures++; end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        i_ir_ex = 16'h0000;
        i_dmem_ack = 1'b0;
        test_reset();
        test_decode();
        test_ldr_ack3();
        test_load_use();
        test_timeout();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
